// File: rtl/disp_mux_if.sv
// Display-multiplexer bus: segment patterns and controls in, scanned anode/segment drive out.
// The testbench (master) drives the inputs and the disp_mux (slave) drives the outputs.
interface disp_mux_if #(
  parameter int unsigned DIGITS = 4
) ();

  logic [8*DIGITS-1:0] sseg_in;
  logic                load;
  logic [DIGITS-1:0]   blank;
  logic [2:0]          bright;
  logic [DIGITS-1:0]   an;
  logic [7:0]          sseg;
  logic                frame_tick;
  logic                busy;

  modport master (
    output sseg_in, load, blank, bright,
    input  an, sseg, frame_tick, busy
  );

  modport slave (
    input  sseg_in, load, blank, bright,
    output an, sseg, frame_tick, busy
  );

endinterface

// File: rtl/disp_mux.sv
// Time-multiplexed common-anode 7-segment driver with a double-buffered frame,
// per-slot dead time against ghosting and a 3-bit duty-cycle brightness control.
module disp_mux #(
  parameter int unsigned DIGITS = 4,
  parameter int unsigned N      = 18,
  parameter int unsigned DEAD   = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  disp_mux_if.slave   bus
);

  localparam int unsigned SEL_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned SEG_W = 8;

  typedef logic [DIGITS-1:0][SEG_W-1:0] frame_t;

  logic [N-1:0]      cnt_q, cnt_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  frame_t            shadow_q, shadow_d;
  frame_t            pend_q, pend_d;
  logic              busy_q, busy_d;
  logic              frame_tick_q, frame_tick_d;
  logic [DIGITS-1:0] an_q, an_d;
  logic [SEG_W-1:0]  sseg_q, sseg_d;

  logic              slot_end_c;
  logic              last_sel_c;
  logic              frame_end_c;
  logic              digit_on_c;
  logic [2:0]        duty_c;
  frame_t            sseg_in_c;

  // Scan position, frame boundary and the on/off decision for the current slot cycle
  always_comb begin
    sseg_in_c   = frame_t'(bus.sseg_in);
    slot_end_c  = (cnt_q == {N{1'b1}});
    last_sel_c  = (sel_q == SEL_W'(DIGITS - 1));
    frame_end_c = slot_end_c && last_sel_c;
    duty_c      = cnt_q[N-1:N-3];
    digit_on_c  = (cnt_q >= N'(DEAD)) && (duty_c <= bus.bright) && !bus.blank[sel_q];
  end

  // Next-state: free-running slot counter, digit select, buffers and registered drive
  always_comb begin
    cnt_d        = cnt_q + N'(1);
    sel_d        = sel_q;
    shadow_d     = shadow_q;
    pend_d       = pend_q;
    busy_d       = busy_q;
    frame_tick_d = frame_end_c;
    an_d         = '1;
    sseg_d       = '1;

    if (slot_end_c) begin
      sel_d = last_sel_c ? '0 : sel_q + SEL_W'(1);
    end

    // A load on the frame-end cycle bypasses pending so it shows in the very next frame
    if (frame_end_c) begin
      if (bus.load) begin
        shadow_d = sseg_in_c;
        pend_d   = sseg_in_c;
      end else if (busy_q) begin
        shadow_d = pend_q;
      end
      busy_d = 1'b0;
    end else if (bus.load) begin
      pend_d = sseg_in_c;
      busy_d = 1'b1;
    end

    // Pattern and anode switch together, so sseg only changes while all anodes are off
    if (digit_on_c) begin
      an_d   = ~(DIGITS'(1) << sel_q);
      sseg_d = shadow_q[sel_q];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q        <= '0;
      sel_q        <= '0;
      shadow_q     <= '1;
      pend_q       <= '1;
      busy_q       <= 1'b0;
      frame_tick_q <= 1'b0;
      an_q         <= '1;
      sseg_q       <= '1;
    end else begin
      cnt_q        <= cnt_d;
      sel_q        <= sel_d;
      shadow_q     <= shadow_d;
      pend_q       <= pend_d;
      busy_q       <= busy_d;
      frame_tick_q <= frame_tick_d;
      an_q         <= an_d;
      sseg_q       <= sseg_d;
    end
  end

  assign bus.an         = an_q;
  assign bus.sseg       = sseg_q;
  assign bus.frame_tick = frame_tick_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_disp_mux.sv
// Scoreboard bench for disp_mux: a cycle-count reference model queues expected outputs,
// an independent monitor pops and compares them one cycle after each rising edge.
module tb_disp_mux;

  localparam int DIGITS = 4;
  localparam int N      = 5;
  localparam int DEAD   = 2;
  localparam int SLOT   = 1 << N;
  localparam int FRAME  = DIGITS * SLOT;

  typedef struct {
    logic [3:0] an;
    logic [7:0] sseg;
    logic       ft;
    logic       busy;
  } exp_t;

  logic clk;
  logic reset_n;
  int   checks;
  int   errors;

  exp_t q[$];

  int         m_t;
  logic [7:0] m_shadow[DIGITS];
  logic [7:0] m_pend[DIGITS];
  logic       m_busy;

  disp_mux_if #(.DIGITS(DIGITS)) bus ();

  disp_mux #(.DIGITS(DIGITS), .N(N), .DEAD(DEAD)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Reference model: position comes from elapsed cycles since reset, not from a counter
  initial begin
    int   cnt;
    int   sel;
    bit   fe;
    bit   on;
    exp_t e;
    forever begin
      @(posedge clk);
      if (!reset_n) begin
        m_t    = 0;
        m_busy = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
          m_shadow[k] = 8'hFF;
          m_pend[k]   = 8'hFF;
        end
      end else begin
        cnt = m_t % SLOT;
        sel = (m_t / SLOT) % DIGITS;
        fe  = (m_t % FRAME) == FRAME - 1;
        on  = (cnt >= DEAD) && ((cnt / (SLOT / 8)) <= int'(bus.bright)) && !bus.blank[sel];
        e.an   = on ? 4'(~(4'b0001 << sel)) : 4'hF;
        e.sseg = on ? m_shadow[sel] : 8'hFF;
        e.ft   = fe;
        if (fe) begin
          for (int k = 0; k < DIGITS; k++)
            m_shadow[k] = bus.load ? bus.sseg_in[8*k +: 8] : (m_busy ? m_pend[k] : m_shadow[k]);
          m_busy = 1'b0;
        end else if (bus.load) begin
          for (int k = 0; k < DIGITS; k++) m_pend[k] = bus.sseg_in[8*k +: 8];
          m_busy = 1'b1;
        end
        e.busy = m_busy;
        q.push_back(e);
        m_t++;
      end
    end
  end

  // Monitor: compare every registered output cycle against the queued expectation
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (reset_n && q.size() > 0) begin
        e = q.pop_front();
        chk("an", 32'(bus.an), 32'(e.an));
        chk("sseg", 32'(bus.sseg), 32'(e.sseg));
        chk("frame_tick", 32'(bus.frame_tick), 32'(e.ft));
        chk("busy", 32'(bus.busy), 32'(e.busy));
        chk("an_at_most_one_low", 32'($countones(~bus.an) <= 1), 32'd1);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_load(input logic [31:0] v);
    bus.sseg_in = v;
    bus.load    = 1'b1;
    @(negedge clk);
    bus.load    = 1'b0;
  endtask

  task automatic wait_phase(input int ph);
    for (int i = 0; i < FRAME && (m_t % FRAME) != ph; i++) @(negedge clk);
  endtask

  task automatic chk_dark(input string tag);
    chk({tag, "_an"}, 32'(bus.an), 32'hF);
    chk({tag, "_sseg"}, 32'(bus.sseg), 32'hFF);
    chk({tag, "_busy"}, 32'(bus.busy), 32'h0);
    chk({tag, "_frame_tick"}, 32'(bus.frame_tick), 32'h0);
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    reset_n     = 1'b1;
    bus.sseg_in = '1;
    bus.load    = 1'b0;
    bus.blank   = '0;
    bus.bright  = 3'd7;
    #1 reset_n  = 1'b0;

    // Reset hold and a first, blank frame with all anodes walking
    cyc(3);
    chk_dark("reset_hold");
    reset_n = 1'b1;
    cyc(FRAME + 10);

    // Known pattern loaded mid-frame, shown from the next frame onward
    do_load(32'h8F9286C0);
    chk("busy_after_load", 32'(bus.busy), 32'h1);
    cyc(2 * FRAME);

    // Two loads in one frame: only the later one ever appears
    wait_phase(20);
    do_load($urandom);
    cyc(7);
    do_load($urandom);
    cyc(2 * FRAME);

    // Load exactly on the frame-end cycle: busy never rises
    wait_phase(FRAME - 1);
    do_load($urandom);
    chk("busy_frame_end_load", 32'(bus.busy), 32'h0);
    cyc(FRAME + 5);

    // Brightness extremes and mid setting
    bus.bright = 3'd0;
    cyc(FRAME);
    bus.bright = 3'd3;
    cyc(FRAME);
    bus.bright = 3'd7;

    // Blank one digit, then toggle the mask mid-slot
    bus.blank = 4'b0100;
    cyc(FRAME);
    for (int i = 0; i < 40; i++) begin
      cyc($urandom_range(1, 20));
      bus.blank = 4'($urandom);
    end
    bus.blank = '0;

    // Randomized mix of loads, brightness and blanking
    for (int i = 0; i < 2500; i++) begin
      bus.sseg_in = $urandom;
      bus.load    = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 63) == 0) bus.bright = 3'($urandom);
      if ($urandom_range(0, 63) == 0) bus.blank  = 4'($urandom);
      @(negedge clk);
    end
    bus.load   = 1'b0;
    bus.blank  = '0;
    bus.bright = 3'd7;
    cyc(FRAME);

    // Async reset mid-slot with data pending: dark at once and pending discarded
    wait_phase(10);
    do_load(32'h12345678);
    cyc(20);
    chk("busy_before_reset", 32'(bus.busy), 32'h1);
    #2 reset_n = 1'b0;
    #1 chk_dark("async_reset");
    q.delete();
    @(negedge clk);
    reset_n = 1'b1;
    cyc(2 * FRAME);
    chk("busy_after_reset", 32'(bus.busy), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
